// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and codes for the data-memory port arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Size field shared with the load/store control word
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_L = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_size_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_size_align : alignment check and read-data zero-extension by size
// Revision       : 1.0
// ---------------------------------------------------------------------------
module mem_size_align
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic [DATA_W-1:0] rdata_ext
);

  always_comb begin
    misaligned = 1'b0;
    rdata_ext  = rdata;
    case (size)
      SZ_B: begin
        misaligned = 1'b0;
        rdata_ext  = DATA_W'(rdata[7:0]);
      end
      SZ_H: begin
        misaligned = addr_lo[0];
        rdata_ext  = DATA_W'(rdata[15:0]);
      end
      SZ_W: begin
        misaligned = (addr_lo[1:0] != 2'b00);
        rdata_ext  = DATA_W'(rdata[31:0]);
      end
      default: begin
        misaligned = (addr_lo != 3'b000);
        rdata_ext  = rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : fetch vs load/store arbitration onto one data-memory port
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int TIMEOUT       = 16,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic              f_err,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [1:0]        l_size,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_done,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  state_t              state_q,   state_d;
  logic [STREAK_W-1:0] streak_q,  streak_d;
  logic [WAIT_W-1:0]   wait_q,    wait_d;
  logic                id_q,      id_d;
  logic                we_q,      we_d;
  logic [1:0]          size_q,    size_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                cs_q,      cs_d;
  logic                f_done_q,  f_done_d;
  logic                f_err_q,   f_err_d;
  logic [31:0]         f_rdata_q, f_rdata_d;
  logic                l_done_q,  l_done_d;
  logic                l_err_q,   l_err_d;
  logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;

  logic              grant_f, grant_l;
  logic [1:0]        cand_size, align_size;
  logic [ADDR_W-1:0] cand_addr;
  logic              misaligned;
  logic [DATA_W-1:0] rdata_ext;
  logic              fin, fin_err, fin_id;
  logic [DATA_W-1:0] fin_data;

  // Shared between grant-time alignment (IDLE) and read masking (ACCESS)
  assign align_size = (state_q == ST_IDLE) ? cand_size : size_q;

  mem_size_align #(.DATA_W(DATA_W)) u_size_align (
    .addr_lo    (cand_addr[2:0]),
    .size       (align_size),
    .rdata      (mem_rdata),
    .misaligned (misaligned),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    grant_f   = f_req && (!l_req || (streak_q == STREAK_MAX));
    grant_l   = l_req && !grant_f;
    cand_size = grant_f ? SZ_W : l_size;
    cand_addr = grant_f ? f_addr : l_addr;

    state_d   = state_q;
    streak_d  = streak_q;
    wait_d    = wait_q;
    id_d      = id_q;
    we_d      = we_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cs_d      = cs_q;
    f_done_d  = 1'b0;
    f_err_d   = 1'b0;
    f_rdata_d = '0;
    l_done_d  = 1'b0;
    l_err_d   = 1'b0;
    l_rdata_d = '0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_data  = '0;
    fin_id    = id_q;

    case (state_q)
      ST_IDLE: begin
        if (!f_req || grant_f) begin
          streak_d = '0;
        end else if (grant_l && (streak_q != STREAK_MAX)) begin
          streak_d = streak_q + 1'b1;
        end
        if (grant_f || grant_l) begin
          fin_id = grant_f ? REQ_F : REQ_L;
          id_d   = fin_id;
          if (misaligned) begin
            state_d = ST_RESP;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            we_d    = grant_l && l_we;
            size_d  = cand_size;
            addr_d  = cand_addr;
            wdata_d = grant_l ? l_wdata : '0;
            wait_d  = '0;
            cs_d    = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          state_d  = ST_RESP;
          cs_d     = 1'b0;
          fin      = 1'b1;
          fin_data = we_q ? '0 : rdata_ext;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_RESP;
          cs_d    = 1'b0;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin) begin
      if (fin_id == REQ_F) begin
        f_done_d  = 1'b1;
        f_err_d   = fin_err;
        f_rdata_d = fin_data[31:0];
      end else begin
        l_done_d  = 1'b1;
        l_err_d   = fin_err;
        l_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      wait_q    <= '0;
      id_q      <= REQ_F;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_q      <= 1'b0;
      f_done_q  <= 1'b0;
      f_err_q   <= 1'b0;
      f_rdata_q <= '0;
      l_done_q  <= 1'b0;
      l_err_q   <= 1'b0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wait_q    <= wait_d;
      id_q      <= id_d;
      we_q      <= we_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cs_q      <= cs_d;
      f_done_q  <= f_done_d;
      f_err_q   <= f_err_d;
      f_rdata_q <= f_rdata_d;
      l_done_q  <= l_done_d;
      l_err_q   <= l_err_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign f_done    = f_done_q;
  assign f_err     = f_err_q;
  assign f_rdata   = f_rdata_q;
  assign l_done    = l_done_q;
  assign l_err     = l_err_q;
  assign l_rdata   = l_rdata_q;
  assign mem_cs    = cs_q;
  assign mem_we    = cs_q && we_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
